dma_dev_buffer: RTL and testbench
=================================

// Module: dma_dev_buffer
// PURPOSE
//  Device-side buffer between a peripheral and dma_controller. RX FIFO carries words
//  peripheral->DMA (DMA wr mode, device->memory); TX FIFO carries words DMA->peripheral
//  (DMA rd mode, memory->device). Drives the DMA's dev_rdy/dev_wdata/error1/error2
//  inputs and consumes its dma_rcv/dma_txd/dev_rdata outputs.
// PARAMETERS
//  DW     32  data word width
//  DEPTH  8   entries per FIFO (power of two)
//  AW     3   log2(DEPTH); occupancy counts are AW+1 bits
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, synchronous, active-high
//  dir        in   1       0: RX path active (device->mem), 1: TX path active (mem->device)
//  flush      in   1       empty both FIFOs, clear push_pend
//  clear_err  in   1       clear sticky error1/error2
//  rx_strobe  in   1       peripheral pushes rx_data (no backpressure)
//  rx_data    in   DW      peripheral word
//  tx_valid   out  1       TX FIFO non-empty
//  tx_data    out  DW      TX FIFO head (show-ahead)
//  tx_ready   in   1       peripheral accepts tx_data when tx_valid&tx_ready
//  dev_rdy    out  1       to DMA: dir=0 RX non-empty; dir=1 TX has free slot
//  dev_wdata  out  DW      to DMA: RX FIFO head (show-ahead), 0 when empty
//  dma_rcv    in   1       from DMA: one-cycle pop strobe for RX head
//  dma_txd    in   1       from DMA: word pending for device
//  dev_rdata  in   DW      from DMA: word, valid cycle after dma_txd&dev_rdy
//  error1     out  1       sticky: RX overflow (rx_strobe while RX full)
//  error2     out  1       sticky: RX underflow (dma_rcv while RX empty) or TX overflow
//  rx_count   out  AW+1    RX occupancy 0..DEPTH
//  tx_count   out  AW+1    TX occupancy 0..DEPTH
// BEHAVIOUR
//  Reset: both FIFOs empty, pointers/counts 0, push_pend 0, error1=error2=0,
//   dev_rdy=0, tx_valid=0, dev_wdata=0, tx_data=0 (outputs combinational from state).
//  RX push: rx_strobe & !full -> write rx_data at wptr, wptr+1 mod DEPTH (wrap).
//   rx_strobe & full -> word dropped, error1<=1.
//  RX pop: dma_rcv & !empty -> rptr+1. DMA latches dev_wdata the edge before dma_rcv
//   rises, so the pop strobe retires the already-captured head. dma_rcv & empty ->
//   no pointer change, error2<=1.
//  RX simultaneous push+pop when full: pop first-order not allowed; push is rejected
//   (error1), pop proceeds. When empty: push accepted, pop flagged (error2).
//   Non-error simultaneous push+pop: count unchanged.
//  TX capture: push_pend <= dma_txd & dev_rdy & dir. Cycle with push_pend=1: write
//   dev_rdata into TX FIFO. dev_rdy (dir=1) = (tx_count + push_pend) < DEPTH, so the
//   pending slot is reserved; push with no room -> dropped, error2<=1.
//  TX drain: tx_valid & tx_ready -> rptr+1; push+pop same cycle keeps count.
//  dev_rdy with dir=0 = rx_count!=0. dir change takes effect next cycle; data in the
//   inactive FIFO is retained.
//  flush: pointers/counts/push_pend to 0 next edge; has priority over same-cycle
//   push/pop; errors unaffected. clear_err: errors 0; a same-cycle error event wins
//   (flag stays 1). rst mid-transfer = full reset state; in-flight word lost.
//  Counts saturate logically at DEPTH (never exceed by construction).
// TESTING
//  T1 dir=0, 3 rx_strobe (A1,A2,A3) -> rx_count=3, dev_rdy=1, dev_wdata=A1;
//     dma_rcv pulse -> dev_wdata=A2, rx_count=2.
//  T2 dir=0, 9 rx_strobe DEPTH=8 -> rx_count=8, error1=1, 9th word absent;
//     drain 8 with dma_rcv -> order preserved across pointer wrap, dev_rdy=0.
//  T3 dma_rcv with RX empty -> error2=1, rx_count=0; clear_err -> error2=0.
//  T4 dir=1, dma_txd=1 & dev_rdy, dev_rdata=0xCAFE0001 next cycle -> tx_valid=1,
//     tx_data=0xCAFE0001; tx_ready -> tx_count=0.
//  T5 dir=1, tx_ready=0, fill to 7 then dma_txd handshake -> dev_rdy=0 during
//     push_pend, tx_count=8 after; no error2.
//  T6 rx_count=5, assert rst (or flush) with rx_strobe&dma_rcv -> counts 0,
//     dev_rdy=0; after rst error1=error2=0.

Source files
------------

// File: rtl/dma_dev_buffer.sv
// Device-side RX/TX word buffer between a peripheral and the DMA controller.
// Ports: clk/rst, dir/flush/clear_err, RX strobe in, TX valid/ready out, DMA side, errors, counts.
module dma_dev_buffer #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dir,
  input  logic          flush,
  input  logic          clear_err,
  input  logic          rx_strobe,
  input  logic [DW-1:0] rx_data,
  output logic          tx_valid,
  output logic [DW-1:0] tx_data,
  input  logic          tx_ready,
  output logic          dev_rdy,
  output logic [DW-1:0] dev_wdata,
  input  logic          dma_rcv,
  input  logic          dma_txd,
  input  logic [DW-1:0] dev_rdata,
  output logic          error1,
  output logic          error2,
  output logic [AW:0]   rx_count,
  output logic [AW:0]   tx_count
);

  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PINC = AW'(1);

  logic [DW-1:0] rx_mem [DEPTH];
  logic [DW-1:0] tx_mem [DEPTH];
  logic [AW-1:0] rx_wptr, rx_rptr;
  logic [AW-1:0] tx_wptr, tx_rptr;
  logic          push_pend;

  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic set_e1, set_e2;
  logic [AW+1:0] tx_resv;

  assign rx_full  = rx_count == FULL;
  assign rx_empty = rx_count == '0;
  assign tx_full  = tx_count == FULL;
  assign tx_empty = tx_count == '0;

  // A full RX rejects the push but still lets the pop retire the head.
  assign rx_push = rx_strobe & ~rx_full;
  assign rx_pop  = dma_rcv & ~rx_empty;
  assign tx_push = push_pend & ~tx_full;
  assign tx_pop  = tx_valid & tx_ready;

  assign set_e1 = rx_strobe & rx_full;
  assign set_e2 = (dma_rcv & rx_empty) | (push_pend & tx_full);

  // The word announced last cycle already owns a slot.
  assign tx_resv = {1'b0, tx_count} + {{(AW+1){1'b0}}, push_pend};

  assign dev_rdy   = dir ? (tx_resv < {1'b0, FULL}) : ~rx_empty;
  assign dev_wdata = rx_empty ? '0 : rx_mem[rx_rptr];
  assign tx_valid  = ~tx_empty;
  assign tx_data   = tx_empty ? '0 : tx_mem[tx_rptr];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
    if (tx_push) tx_mem[tx_wptr] <= dev_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rx_wptr   <= '0;
      rx_rptr   <= '0;
      rx_count  <= '0;
      tx_wptr   <= '0;
      tx_rptr   <= '0;
      tx_count  <= '0;
      push_pend <= 1'b0;
    end else begin
      push_pend <= dma_txd & dev_rdy & dir;
      if (rx_push) rx_wptr <= rx_wptr + PINC;
      if (rx_pop)  rx_rptr <= rx_rptr + PINC;
      if (rx_push && !rx_pop) rx_count <= rx_count + ONE;
      else if (!rx_push && rx_pop) rx_count <= rx_count - ONE;
      if (tx_push) tx_wptr <= tx_wptr + PINC;
      if (tx_pop)  tx_rptr <= tx_rptr + PINC;
      if (tx_push && !tx_pop) tx_count <= tx_count + ONE;
      else if (!tx_push && tx_pop) tx_count <= tx_count - ONE;
    end
  end

  // A new error event in the same cycle as clear_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      error1 <= 1'b0;
      error2 <= 1'b0;
    end else begin
      error1 <= set_e1 | (error1 & ~clear_err);
      error2 <= set_e2 | (error2 & ~clear_err);
    end
  end

endmodule

// File: tb/tb_dma_dev_buffer.sv
// Directed bench for dma_dev_buffer: vector table plus multi-cycle sequences.
// Drives inputs #1 after the rising edge and checks outputs there.
module tb_dma_dev_buffer;

  logic        clk = 1'b0;
  logic        rst, dir, flush, clear_err, rx_strobe, tx_ready;
  logic        dma_rcv, dma_txd;
  logic [31:0] rx_data, dev_rdata;
  logic        tx_valid, dev_rdy, error1, error2;
  logic [31:0] tx_data, dev_wdata;
  logic [3:0]  rx_count, tx_count;

  int nchk = 0;
  int nerr = 0;

  dma_dev_buffer #(.DW(32), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .dir(dir), .flush(flush),
    .clear_err(clear_err), .rx_strobe(rx_strobe), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .dev_rdy(dev_rdy), .dev_wdata(dev_wdata), .dma_rcv(dma_rcv),
    .dma_txd(dma_txd), .dev_rdata(dev_rdata), .error1(error1),
    .error2(error2), .rx_count(rx_count), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dir;
    logic        clr;
    logic        strb;
    logic [31:0] rxd;
    logic        rcv;
    logic [3:0]  e_rxc;
    logic [3:0]  e_txc;
    logic        e_rdy;
    logic [31:0] e_wd;
    logic        e_e1;
    logic        e_e2;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; clear_err = 0; rx_strobe = 0; rx_data = '0;
    tx_ready = 0; dma_rcv = 0; dma_txd = 0; dev_rdata = '0;
  endtask

  initial begin
    vecs[0]  = '{0,0,1,32'hA1,0, 1,0,1,32'hA1,0,0};
    vecs[1]  = '{0,0,1,32'hA2,0, 2,0,1,32'hA1,0,0};
    vecs[2]  = '{0,0,1,32'hA3,0, 3,0,1,32'hA1,0,0};
    vecs[3]  = '{0,0,0,32'h0, 1, 2,0,1,32'hA2,0,0};
    vecs[4]  = '{0,0,1,32'hA4,1, 2,0,1,32'hA3,0,0};
    vecs[5]  = '{0,0,0,32'h0, 1, 1,0,1,32'hA4,0,0};
    vecs[6]  = '{0,0,0,32'h0, 1, 0,0,0,32'h0, 0,0};
    vecs[7]  = '{0,0,0,32'h0, 1, 0,0,0,32'h0, 0,1};
    vecs[8]  = '{0,1,0,32'h0, 0, 0,0,0,32'h0, 0,0};
    vecs[9]  = '{0,1,0,32'h0, 1, 0,0,0,32'h0, 0,1};
    vecs[10] = '{0,1,0,32'h0, 0, 0,0,0,32'h0, 0,0};
    vecs[11] = '{0,0,1,32'hB1,1, 1,0,1,32'hB1,0,1};
    vecs[12] = '{0,1,0,32'h0, 1, 0,0,0,32'h0, 0,0};
    vecs[13] = '{1,0,0,32'h0, 0, 0,0,1,32'h0, 0,0};

    idle();
    dir = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst_rx_count", 32'(rx_count), 0);
    chk("rst_tx_count", 32'(tx_count), 0);
    chk("rst_dev_rdy", 32'(dev_rdy), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_dev_wdata", dev_wdata, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_errors", {30'd0, error1, error2}, 0);

    foreach (vecs[i]) begin
      idle();
      dir = vecs[i].dir; clear_err = vecs[i].clr;
      rx_strobe = vecs[i].strb; rx_data = vecs[i].rxd;
      dma_rcv = vecs[i].rcv;
      tick();
      chk($sformatf("v%0d_rx_count", i), 32'(rx_count), 32'(vecs[i].e_rxc));
      chk($sformatf("v%0d_tx_count", i), 32'(tx_count), 32'(vecs[i].e_txc));
      chk($sformatf("v%0d_dev_rdy", i), 32'(dev_rdy), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_dev_wdata", i), dev_wdata, vecs[i].e_wd);
      chk($sformatf("v%0d_error1", i), 32'(error1), 32'(vecs[i].e_e1));
      chk($sformatf("v%0d_error2", i), 32'(error2), 32'(vecs[i].e_e2));
    end

    // RX overflow and drain across pointer wrap
    idle(); dir = 0;
    for (int i = 0; i < 9; i++) begin
      rx_strobe = 1; rx_data = 32'h100 + 32'(i);
      tick();
    end
    idle();
    chk("ovf_rx_count", 32'(rx_count), 8);
    chk("ovf_error1", 32'(error1), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_wdata", i), dev_wdata, 32'h100 + 32'(i));
      dma_rcv = 1;
      tick();
      dma_rcv = 0;
    end
    chk("drain_rx_count", 32'(rx_count), 0);
    chk("drain_dev_rdy", 32'(dev_rdy), 0);
    chk("drain_wdata_zero", dev_wdata, 0);
    clear_err = 1; tick(); clear_err = 0;
    chk("clr_error1", 32'(error1), 0);

    // TX single word
    idle(); dir = 1;
    dma_txd = 1; tick(); dma_txd = 0;
    chk("tx1_dev_rdy_pend", 32'(dev_rdy), 1);
    dev_rdata = 32'hCAFE0001; tick(); dev_rdata = '0;
    chk("tx1_valid", 32'(tx_valid), 1);
    chk("tx1_data", tx_data, 32'hCAFE0001);
    chk("tx1_count", 32'(tx_count), 1);
    tx_ready = 1; tick(); tx_ready = 0;
    chk("tx1_drained", 32'(tx_count), 0);
    chk("tx1_valid_off", 32'(tx_valid), 0);

    // TX fill to 7, then last handshake reserves the final slot
    for (int i = 0; i < 7; i++) begin
      dma_txd = 1; tick(); dma_txd = 0;
      dev_rdata = 32'h200 + 32'(i); tick(); dev_rdata = '0;
    end
    chk("tx7_count", 32'(tx_count), 7);
    chk("tx7_dev_rdy", 32'(dev_rdy), 1);
    dma_txd = 1; tick(); dma_txd = 0;
    chk("tx_pend_dev_rdy", 32'(dev_rdy), 0);
    dev_rdata = 32'h207; tick(); dev_rdata = '0;
    chk("tx8_count", 32'(tx_count), 8);
    chk("tx8_dev_rdy", 32'(dev_rdy), 0);
    chk("tx8_error2", 32'(error2), 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("txd%0d_data", i), tx_data, 32'h200 + 32'(i));
      tx_ready = 1; tick(); tx_ready = 0;
    end
    chk("txd_count", 32'(tx_count), 0);

    // flush and reset mid-transfer
    idle(); dir = 0;
    dma_rcv = 1; tick(); dma_rcv = 0;
    chk("fl_pre_error2", 32'(error2), 1);
    for (int i = 0; i < 5; i++) begin
      rx_strobe = 1; rx_data = 32'h300 + 32'(i); tick();
    end
    rx_strobe = 0;
    chk("fl_rx5", 32'(rx_count), 5);
    flush = 1; rx_strobe = 1; dma_rcv = 1; tick();
    idle();
    chk("fl_rx_count", 32'(rx_count), 0);
    chk("fl_dev_rdy", 32'(dev_rdy), 0);
    chk("fl_error2_kept", 32'(error2), 1);
    for (int i = 0; i < 5; i++) begin
      rx_strobe = 1; rx_data = 32'h400 + 32'(i); tick();
    end
    rx_strobe = 0;
    chk("rs_rx5", 32'(rx_count), 5);
    chk("rs_wdata", dev_wdata, 32'h400);
    rst = 1; rx_strobe = 1; dma_rcv = 1; tick();
    rst = 0; idle();
    chk("rs_rx_count", 32'(rx_count), 0);
    chk("rs_tx_count", 32'(tx_count), 0);
    chk("rs_dev_rdy", 32'(dev_rdy), 0);
    chk("rs_errors", {30'd0, error1, error2}, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
